// File: rtl/amo_rmw_ctrl_pkg.sv
// amo_rmw_ctrl_pkg: core config type, AMO opcodes and sequencer state encoding
package amo_rmw_ctrl_pkg;
  typedef struct packed {
    int XLEN;
    int PA_BITS;
  } cvw_t;
  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, PA_BITS: 56};
  localparam logic [4:0] AMO_LR = 5'b00010;
  localparam logic [4:0] AMO_SC = 5'b00011;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} amostatetype;
endpackage

// File: rtl/amo_reservation.sv
// amo_reservation: LR/SC reservation (set/set_adr from LR, clr from SC, ext_we/ext_adr snoop, hit = valid and chk_adr in granule)
module amo_reservation #(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic               clr,
  input  logic [PA_BITS-1:0] set_adr,
  input  logic [PA_BITS-1:0] chk_adr,
  input  logic               ext_we,
  input  logic [PA_BITS-1:0] ext_adr,
  output logic               hit
);
  localparam int G = $clog2(XLEN / 8);
  logic               valid;
  logic [PA_BITS-1:G] adr;
  logic [PA_BITS-1:G] cmp_adr;
  logic               ext_hit;
  logic               unused;
  assign unused  = &{1'b0, set_adr[G-1:0], chk_adr[G-1:0], ext_adr[G-1:0]};
  // a snooped write against the granule being set this cycle must also kill it
  assign cmp_adr = set ? set_adr[PA_BITS-1:G] : adr;
  assign ext_hit = ext_we & (ext_adr[PA_BITS-1:G] == cmp_adr);
  assign hit     = valid & (adr == chk_adr[PA_BITS-1:G]);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      adr   <= '0;
    end else begin
      valid <= (set | valid) & ~(clr | ext_hit);
      adr   <= cmp_adr;
    end
  end
endmodule

// File: rtl/amoalu.sv
// amoalu: AMO arithmetic/logic step (srca = old memory value, srcb = rs2, funct = funct7[6:2], result = value to store)
module amoalu #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [4:0]      funct,
  output logic [XLEN-1:0] result
);
  logic lt, ltu;
  assign lt  = $signed(srca) < $signed(srcb);
  assign ltu = srca < srcb;
  always_comb begin
    result = '0;
    case (funct)
      5'b00000: result = srca + srcb;
      5'b00001: result = srcb;
      5'b00100: result = srca ^ srcb;
      5'b01000: result = srca | srcb;
      5'b01100: result = srca & srcb;
      5'b10000: result = lt ? srca : srcb;
      5'b10100: result = lt ? srcb : srca;
      5'b11000: result = ltu ? srca : srcb;
      5'b11100: result = ltu ? srcb : srca;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/amo_rmw_ctrl.sv
// amo_rmw_ctrl: AMO/LR/SC bus read-modify-write sequencer (pipeline req/stall/done, bus read/write/ack, external write snoop)
module amo_rmw_ctrl
  import amo_rmw_ctrl_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   AMOReqM,
  input  logic                   FlushM,
  input  logic [6:0]             LSUFunct7M,
  input  logic [2:0]             LSUFunct3M,
  input  logic [P.PA_BITS-1:0]   PAdrM,
  input  logic [P.XLEN-1:0]      WriteDataM,
  output logic                   AMOStallM,
  output logic                   AMODoneM,
  output logic [P.XLEN-1:0]      AMOReadDataM,
  output logic                   BusRead,
  output logic                   BusWrite,
  output logic [P.PA_BITS-1:0]   BusAdr,
  output logic [P.XLEN/8-1:0]    BusByteEn,
  output logic [P.XLEN-1:0]      BusWriteData,
  input  logic                   BusAck,
  input  logic [P.XLEN-1:0]      BusReadData,
  input  logic                   ExtWriteM,
  input  logic [P.PA_BITS-1:0]   ExtWriteAdr
);
  localparam int XLEN = P.XLEN;
  localparam int PA   = P.PA_BITS;
  amostatetype     state, state_n;
  logic [4:0]      op;
  logic            dbl;
  logic [PA-1:0]   adr;
  logic [XLEN-1:0] rs2, old, rd, rd_ext, ihwd, alu_res, wd_src;
  logic            start, is_lr, is_sc, res_hit;
  logic            unused;
  assign unused       = &{1'b0, LSUFunct7M[1:0], LSUFunct3M[2:1]};
  assign start        = (state == IDLE) & AMOReqM & ~FlushM;
  assign is_lr        = op == AMO_LR;
  assign is_sc        = op == AMO_SC;
  assign AMOStallM    = (state == IDLE) ? AMOReqM & ~FlushM : state != DONE;
  assign AMODoneM     = state == DONE;
  assign BusRead      = state == READ;
  assign BusWrite     = state == WRITE;
  assign BusAdr       = adr;
  assign AMOReadDataM = rd;
  assign wd_src       = is_sc ? rs2 : alu_res;
  generate
    if (XLEN == 64) begin : g_rv64
      logic [31:0] lane;
      assign lane         = adr[2] ? BusReadData[63:32] : BusReadData[31:0];
      assign rd_ext       = dbl ? BusReadData : {{32{lane[31]}}, lane};
      assign ihwd         = dbl ? rs2 : {{32{rs2[31]}}, rs2[31:0]};
      assign BusWriteData = dbl ? wd_src : {2{wd_src[31:0]}};
      assign BusByteEn    = dbl ? 8'hFF : adr[2] ? 8'hF0 : 8'h0F;
    end else begin : g_rv32
      assign rd_ext       = BusReadData;
      assign ihwd         = rs2;
      assign BusWriteData = wd_src;
      assign BusByteEn    = '1;
    end
  endgenerate
  amoalu #(.XLEN(XLEN)) alu (
    .srca  (old),
    .srcb  (ihwd),
    .funct (op),
    .result(alu_res)
  );
  amo_reservation #(.XLEN(XLEN), .PA_BITS(PA)) resv (
    .clk    (clk),
    .reset  (reset),
    .set    ((state == READ) & BusAck & is_lr),
    .clr    ((state == DONE) & is_sc),
    .set_adr(adr),
    .chk_adr(PAdrM),
    .ext_we (ExtWriteM),
    .ext_adr(ExtWriteAdr),
    .hit    (res_hit)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ~start ? IDLE : (LSUFunct7M[6:2] != AMO_SC) ? READ : res_hit ? WRITE : DONE;
      READ:    state_n = ~BusAck ? READ : is_lr ? DONE : WRITE;
      WRITE:   state_n = BusAck ? DONE : WRITE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= '0;
      dbl   <= 1'b0;
      adr   <= '0;
      rs2   <= '0;
      old   <= '0;
      rd    <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        op  <= LSUFunct7M[6:2];
        dbl <= LSUFunct3M[0];
        adr <= PAdrM;
        rs2 <= WriteDataM;
        if ((LSUFunct7M[6:2] == AMO_SC) & ~res_hit) rd <= XLEN'(1);
      end
      if ((state == READ) & BusAck) begin
        old <= rd_ext;
        rd  <= rd_ext;
      end
      if ((state == WRITE) & BusAck & is_sc) rd <= '0;
    end
  end
endmodule

// File: doc/amo_rmw_ctrl.md
Name: amo_rmw_ctrl

Overview:
- Sequencer for atomic memory operations on the uncached/bus path.
- Turns one memory-stage AMO, LR or SC into a bus read, an ALU step and a bus write, or a subset of these.
- Drives the existing AMO ALU (amoalu) from latched operands.
- Owns the LR/SC reservation and stalls the pipeline until the operation retires.

Parameters:
P  cvw_t default config  core configuration; uses P.XLEN and P.PA_BITS.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
AMOReqM  in  1  memory-stage atomic request valid
FlushM  in  1  memory-stage flush
LSUFunct7M  in  7  atomic opcode; [6:2] selects operation
LSUFunct3M  in  3  access width; 010 = word, 011 = double
PAdrM  in  P.PA_BITS  physical address, naturally aligned
WriteDataM  in  P.XLEN  rs2 operand
AMOStallM  out  1  hold pipeline
AMODoneM  out  1  one-cycle retire strobe
AMOReadDataM  out  P.XLEN  value written to rd
BusRead  out  1  bus read request
BusWrite  out  1  bus write request
BusAdr  out  P.PA_BITS  latched address
BusByteEn  out  P.XLEN/8  write byte enables
BusWriteData  out  P.XLEN  write data
BusAck  in  1  bus transaction complete
BusReadData  in  P.XLEN  read data, valid with BusAck
ExtWriteM  in  1  write by another agent or hart
ExtWriteAdr  in  P.PA_BITS  address of that write

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - BusRead, BusWrite, AMODoneM = 0.
  - AMOReadDataM = 0.
  - Reservation invalid.
  - Operand registers = 0.
- States: IDLE, READ, WRITE, DONE.
- AMOStallM = AMOReqM & ~FlushM in IDLE (combinational). It is 1 in READ and WRITE, and 0 in DONE.
- IDLE:
  - On AMOReqM & ~FlushM, latch funct7, funct3, PAdrM and WriteDataM.
  - LR or AMO -> READ.
  - SC with valid reservation and matching set -> WRITE.
  - SC otherwise -> DONE with fail; no bus traffic.
  - FlushM blocks the start.
- READ:
  - BusRead = 1 until BusAck.
  - On BusAck, capture the lane-selected, sign-extended old value (OldVal).
  - LR: set the reservation to BusAdr and go to DONE.
  - AMO: go to WRITE.
- WRITE:
  - BusWrite = 1 until BusAck.
  - AMO data is the ALU result, with ReadDataM = OldVal and IHWriteDataM = latched rs2.
  - SC data is the latched rs2.
  - On BusAck -> DONE.
- DONE: AMODoneM = 1 for exactly one cycle, then IDLE.
- AMOReadDataM is held from DONE until the next start:
  - AMO/LR: OldVal.
  - SC: 0 on success, 1 on fail.
- Bus transactions are never aborted. FlushM is ignored outside IDLE; the pipeline cannot flush a stalled M stage.
- Width rules, P.XLEN = 64:
  - Word ops use lane BusAdr[2].
  - BusByteEn = 0x0F or 0xF0.
  - Write data replicated to both halves.
  - Double ops: BusByteEn = 0xFF.
- Width rules, P.XLEN = 32: BusByteEn = 0xF always.
- Reservation granule is P.XLEN/8 bytes. Addresses are compared on [PA_BITS-1 : log2(XLEN/8)].
- Reservation is cleared by:
  - any SC at its DONE, pass or fail;
  - ExtWriteM to a matching granule, in any state;
  - reset.
- ExtWriteM matching in the same cycle an LR sets the reservation: clear wins.
- ExtWriteM matching while an SC is in WRITE: the write still completes and the SC reports success. The reservation was valid at issue; upstream ordering is responsible.
- Reset mid-transaction: immediate return to IDLE, bus requests dropped next cycle, reservation cleared.
- Unsupported funct7[6:2]: treated as AMO; the ALU result is don't-care. The decoder guarantees this never occurs.

Decomposition:
- Shared package cvw holds:
  - constants AMO_LR = 5'b00010 and AMO_SC = 5'b00011;
  - typedef enum amostatetype {IDLE, READ, WRITE, DONE}.
- Sub-module amo_reservation holds the valid bit, granule address, set/clear logic and match output.
- The controller instantiates amo_reservation and the AMO ALU.

Test Plan:
- amoadd.d: mem[0x1000]=5, rs2=3, BusAck after 2 cycles each way.
  -> BusWriteData=8, BusByteEn=0xFF, AMOReadDataM=5, one AMODoneM, stall covers all cycles.
- amomin.w at 0x1004: mem word=0xFFFFFFFF, rs2=1.
  -> write 0xFFFFFFFF_FFFFFFFF with BusByteEn=0xF0, AMOReadDataM=0xFFFFFFFF_FFFFFFFF.
- lr.d 0x2000 then sc.d 0x2000 with rs2=0xAB.
  -> bus write of 0xAB, AMOReadDataM=0, reservation invalid afterwards.
- lr.d 0x2000, ExtWriteM at 0x2004, then sc.d 0x2000.
  -> no BusWrite, AMOReadDataM=1, 1-cycle stall.
- LR ack in the same cycle as a matching ExtWriteM.
  -> reservation invalid, following SC fails.
- reset asserted in WRITE.
  -> next cycle BusWrite=0, state IDLE, AMOStallM=0.
- FlushM with AMOReqM in IDLE.
  -> no bus request, no AMODoneM.
